// File: rtl/multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// MULT_DONE_EN (optional) adds a one-cycle done strobe on the top.
package multiplier_pkg;

  localparam int unsigned MULT_WIDTH = 4;
  localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multiplier_ctrl.sv
// Sequencer for the multiplier: IDLE -> CALC (WIDTH steps) -> DONE.
// Emits load/step/store strobes consumed by the datapath in the top.
module multiplier_ctrl
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic step,
  output logic store
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    store   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        store   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// Define MULT_DONE_EN to add the done output strobe.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               start,
`ifdef MULT_DONE_EN
  output logic [2*WIDTH-1:0] result,
  output logic               done
`else
  output logic [2*WIDTH-1:0] result
`endif
);

  logic load, step, store;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;

  multiplier_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .load  (load),
    .step  (step),
    .store (store)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      p_q      <= '0;
      q_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      p_q      <= p_d;
      q_q      <= q_d;
      result_q <= result_d;
    end
  end

  // P carries one extra bit so the add never loses its carry before the shift.
  always_comb begin
    a_d      = a_q;
    p_d      = p_q;
    q_d      = q_q;
    result_d = result_q;
    addend   = q_q[0] ? {1'b0, a_q} : '0;
    sum      = p_q + addend;
    if (load) begin
      a_d = in1;
      q_d = in2;
      p_d = '0;
    end
    if (step) begin
      p_d = {1'b0, sum[WIDTH:1]};
      q_d = {sum[0], q_q[WIDTH-1:1]};
    end
    if (store) begin
      result_d = {p_q[WIDTH-1:0], q_q};
    end
  end

  assign result = result_q;

`ifdef MULT_DONE_EN
  logic done_q, done_d;

  always_comb begin
    done_d = store;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed corners plus random
// back-to-back operations against a plain a*b reference.
module tb_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           start;
  logic [2*W-1:0] result;
`ifdef MULT_DONE_EN
  logic           done;
`endif

  int passed;
  int total;

  multiplier #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst_n),
    .in1    (in1),
    .in2    (in2),
    .start  (start),
`ifdef MULT_DONE_EN
    .result (result),
    .done   (done)
`else
    .result (result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input int a, input int b);
    return (2*W)'(a * b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] exp;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    rst_n = 1'b0;
    #3;
    total++;
    if (result !== '0)
      $display("FAIL reset_state: got %0d want 0", result);
    else passed++;
    rst_n = 1'b1;
    tick();
    in1   = 4'd3;
    in2   = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    total++;
    if (result !== '0)
      $display("FAIL no_partial_edge5: got %0d want 0", result);
    else passed++;
    tick();
    exp = ref_mul(3, 5);
    total++;
    if (result !== exp)
      $display("FAIL basic_3x5: got %0d want %0d", result, exp);
    else passed++;
  endtask

  task automatic test_exhaustive();
    logic [2*W-1:0] exp;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_reset();
        tick();
        in1   = W'(a);
        in2   = W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        exp = ref_mul(a, b);
        total++;
        if (result !== exp)
          $display("FAIL exhaustive %0dx%0d: got %0d want %0d",
                   a, b, result, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    in1   = 4'd2;
    in2   = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    total++;
    if (result !== ref_mul(2, 2))
      $display("FAIL pre_abort_2x2: got %0d want 4", result);
    else passed++;
    in1   = 4'd7;
    in2   = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (result !== '0)
      $display("FAIL abort_immediate: got %0d want 0", result);
    else passed++;
    #1;
    rst_n = 1'b1;
    repeat (10) tick();
    total++;
    if (result !== '0)
      $display("FAIL abort_no_update: got %0d want 0", result);
    else passed++;
  endtask

  task automatic test_busy_start();
    do_reset();
    tick();
    in1   = 4'd2;
    in2   = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    in1   = 4'd15;
    in2   = 4'd15;
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    total++;
    if (result !== ref_mul(2, 3))
      $display("FAIL busy_result: got %0d want 6", result);
    else passed++;
    repeat (10) tick();
    total++;
    if (result !== ref_mul(2, 3))
      $display("FAIL busy_hold: got %0d want 6", result);
    else passed++;
  endtask

  task automatic test_operand_change();
    do_reset();
    tick();
    in1   = 4'd4;
    in2   = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    in1   = 4'd13;
    in2   = 4'd11;
    repeat (5) tick();
    total++;
    if (result !== ref_mul(4, 4))
      $display("FAIL operand_change: got %0d want 16", result);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int a, b;
    logic [2*W-1:0] exp;
    do_reset();
    tick();
    a     = $urandom_range(0, (1 << W) - 1);
    b     = $urandom_range(0, (1 << W) - 1);
    in1   = W'(a);
    in2   = W'(b);
    start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      exp = ref_mul(a, b);
      in1 = W'($urandom);
      in2 = W'($urandom);
      repeat (5) tick();
      total++;
      if (result !== exp)
        $display("FAIL back_to_back[%0d] %0dx%0d: got %0d want %0d",
                 k, a, b, result, exp);
      else passed++;
      a   = $urandom_range(0, (1 << W) - 1);
      b   = $urandom_range(0, (1 << W) - 1);
      in1 = W'(a);
      in2 = W'(b);
    end
    start = 1'b0;
    repeat (8) tick();
  endtask

`ifdef MULT_DONE_EN
  task automatic test_done();
    int pulses;
    int a, b;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      tick();
      a      = $urandom_range(0, (1 << W) - 1);
      b      = $urandom_range(0, (1 << W) - 1);
      pulses = 0;
      in1    = W'(a);
      in2    = W'(b);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int e = 2; e <= 14; e++) begin
        tick();
        if (done === 1'b1) pulses++;
        if (e == 6) begin
          total++;
          if (done !== 1'b1 || result !== ref_mul(a, b))
            $display("FAIL done_pulse[%0d]: got done=%0b res=%0d want 1/%0d",
                     k, done, result, ref_mul(a, b));
          else passed++;
        end
      end
      total++;
      if (pulses != 1)
        $display("FAIL done_count[%0d]: got %0d want 1", k, pulses);
      else passed++;
    end
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b1;
    start  = 1'b0;
    in1    = '0;
    in2    = '0;
    test_reset();
    test_exhaustive();
    test_reset_mid();
    test_busy_start();
    test_operand_change();
    test_back_to_back();
`ifdef MULT_DONE_EN
    test_done();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
